// File: rtl/jailbreak_audio_pkg.sv
// Shared widths, FSM/MAC encodings, coefficient defaults and helpers for the audio filter path.
// Pure definitions: no latency, no flow control.
package jailbreak_audio_pkg;

    localparam int COEF_W  = 18;
    localparam int Q_SHIFT = 15;
    localparam int ACC_W   = 38;
    localparam int SMP_W   = 16;
    localparam int MAX_CH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MB1,
        ST_MB2,
        ST_MA2,
        ST_WB,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MAC_HOLD,
        MAC_LOAD,
        MAC_ADD,
        MAC_SUB
    } mac_op_e;

    localparam logic [1:0] CFG_SEL_B1   = 2'd0;
    localparam logic [1:0] CFG_SEL_B2   = 2'd1;
    localparam logic [1:0] CFG_SEL_A2   = 2'd2;
    localparam logic [1:0] CFG_SEL_NONE = 2'd3;

    localparam logic signed [COEF_W-1:0] COEF_DEF_B  = 18'sd1488;
    localparam logic signed [COEF_W-1:0] COEF_DEF_A2 = -18'sd29791;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 38'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -38'sd32768;

    function automatic logic signed [COEF_W-1:0] sext_smp(input logic signed [SMP_W-1:0] v);
        return {{(COEF_W-SMP_W){v[SMP_W-1]}}, v};
    endfunction

    function automatic logic signed [SMP_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return 16'sh7FFF;
        else if (v < SAT_MIN)
            return 16'sh8000;
        else
            return v[SMP_W-1:0];
    endfunction

endpackage

// File: rtl/jailbreak_iir_mac.sv
// Shared 18x18 multiply with load/add/sub into a 38-bit accumulator, plus Q15 rescale and 16-bit clamp.
// Combinational (caller registers the accumulator); no flow control.
module jailbreak_iir_mac
    import jailbreak_audio_pkg::*;
(
    input  mac_op_e                   i_op,
    input  logic signed [COEF_W-1:0]  i_coef,
    input  logic signed [COEF_W-1:0]  i_sample,
    input  logic signed [ACC_W-1:0]   i_acc,
    output logic signed [ACC_W-1:0]   o_acc,
    output logic signed [SMP_W-1:0]   o_sat
);

    logic signed [2*COEF_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_shr;

    assign w_prod     = i_coef * i_sample;
    assign w_prod_ext = {{(ACC_W-2*COEF_W){w_prod[2*COEF_W-1]}}, w_prod};

    always_comb begin
        o_acc = i_acc;
        unique case (i_op)
            MAC_LOAD: o_acc = w_prod_ext;
            MAC_ADD:  o_acc = i_acc + w_prod_ext;
            MAC_SUB:  o_acc = i_acc - w_prod_ext;
            default:  o_acc = i_acc;
        endcase
    end

    // Arithmetic shift floors toward -inf, matching the reference filter.
    assign w_shr = i_acc >>> Q_SHIFT;
    assign o_sat = sat16(w_shr);

endmodule

// File: rtl/jailbreak_lpf_sched.sv
// Time-multiplexed first-order IIR low-pass over CHANNELS lanes sharing one MAC; tick every max(div,4*CHANNELS+2) clks.
// Output 4*CHANNELS+2 cycles after tick; config writes accepted only while idle (cfg_ready).
module jailbreak_lpf_sched
    import jailbreak_audio_pkg::*;
#(
    parameter int                       CHANNELS    = 2,
    parameter logic signed [COEF_W-1:0] COEF_RST_B  = COEF_DEF_B,
    parameter logic signed [COEF_W-1:0] COEF_RST_A2 = COEF_DEF_A2
)(
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [9:0]                  i_div,
    input  logic [16*CHANNELS-1:0]      i_in,
    input  logic                        i_cfg_we,
    output logic                        o_cfg_ready,
    input  logic [1:0]                  i_cfg_ch,
    input  logic [1:0]                  i_cfg_sel,
    input  logic signed [COEF_W-1:0]    i_cfg_data,
    output logic [16*CHANNELS-1:0]      o_out,
    output logic                        o_out_valid
);

    localparam logic [9:0] P_MIN   = 10'(4*CHANNELS+2);
    localparam logic [2:0] NCH     = 3'(CHANNELS);
    localparam logic [1:0] LAST_CH = 2'(CHANNELS-1);

    state_e                     r_state;
    state_e                     w_next;
    logic [9:0]                 r_cnt;
    logic [9:0]                 w_period;
    logic                       w_tick;
    logic [1:0]                 r_ch;
    logic signed [ACC_W-1:0]    r_acc;
    logic signed [ACC_W-1:0]    w_acc_nxt;
    logic signed [SMP_W-1:0]    w_sat;
    mac_op_e                    w_mac_op;
    logic signed [COEF_W-1:0]   w_coef;
    logic signed [COEF_W-1:0]   w_sample;
    logic                       w_cfg_acc;

    logic signed [SMP_W-1:0]    r_xcap [MAX_CH];
    logic signed [SMP_W-1:0]    r_x1   [MAX_CH];
    logic signed [SMP_W-1:0]    r_y1   [MAX_CH];
    logic signed [COEF_W-1:0]   r_b1   [MAX_CH];
    logic signed [COEF_W-1:0]   r_b2   [MAX_CH];
    logic signed [COEF_W-1:0]   r_a2   [MAX_CH];
    logic [16*CHANNELS-1:0]     r_out;
    logic                       r_out_valid;

    // Period floor guarantees the full channel sweep fits between ticks.
    assign w_period = (i_div > P_MIN) ? i_div : P_MIN;
    assign w_tick   = (r_cnt >= w_period - 10'd1);

    assign o_cfg_ready = (r_state == ST_IDLE);
    assign w_cfg_acc   = i_cfg_we && o_cfg_ready && ({1'b0, i_cfg_ch} < NCH);
    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_tick ? 10'd0 : r_cnt + 10'd1;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_mac_op = MAC_HOLD;
        w_coef   = '0;
        w_sample = '0;
        unique case (r_state)
            ST_IDLE: if (w_tick) w_next = ST_MB1;
            ST_MB1: begin
                w_mac_op = MAC_LOAD;
                w_coef   = r_b1[r_ch];
                w_sample = sext_smp(r_xcap[r_ch]);
                w_next   = ST_MB2;
            end
            ST_MB2: begin
                w_mac_op = MAC_ADD;
                w_coef   = r_b2[r_ch];
                w_sample = sext_smp(r_x1[r_ch]);
                w_next   = ST_MA2;
            end
            ST_MA2: begin
                w_mac_op = MAC_SUB;
                w_coef   = r_a2[r_ch];
                w_sample = sext_smp(r_y1[r_ch]);
                w_next   = ST_WB;
            end
            ST_WB:   w_next = (r_ch == LAST_CH) ? ST_DONE : ST_MB1;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    jailbreak_iir_mac u_mac (
        .i_op     (w_mac_op),
        .i_coef   (w_coef),
        .i_sample (w_sample),
        .i_acc    (r_acc),
        .o_acc    (w_acc_nxt),
        .o_sat    (w_sat)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc       <= '0;
            r_ch        <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            for (int c = 0; c < MAX_CH; c++) begin
                r_xcap[c] <= '0;
                r_x1[c]   <= '0;
                r_y1[c]   <= '0;
                r_b1[c]   <= COEF_RST_B;
                r_b2[c]   <= COEF_RST_B;
                r_a2[c]   <= COEF_RST_A2;
            end
        end else begin
            r_acc       <= w_acc_nxt;
            r_out_valid <= 1'b0;
            // Same-edge write lands before MB1 reads the bank on the next cycle.
            if (w_cfg_acc) begin
                unique case (i_cfg_sel)
                    CFG_SEL_B1: r_b1[i_cfg_ch] <= i_cfg_data;
                    CFG_SEL_B2: r_b2[i_cfg_ch] <= i_cfg_data;
                    CFG_SEL_A2: r_a2[i_cfg_ch] <= i_cfg_data;
                    default: ;
                endcase
            end
            if (r_state == ST_IDLE && w_tick) begin
                r_ch <= '0;
                for (int c = 0; c < CHANNELS; c++)
                    r_xcap[c] <= i_in[16*c +: 16];
            end
            if (r_state == ST_WB) begin
                r_y1[r_ch] <= w_sat;
                r_x1[r_ch] <= r_xcap[r_ch];
                r_ch       <= r_ch + 2'd1;
            end
            if (r_state == ST_DONE) begin
                r_out_valid <= 1'b1;
                for (int c = 0; c < CHANNELS; c++)
                    r_out[16*c +: 16] <= r_y1[c];
            end
        end
    end

endmodule
